abr_masked_mux_pipe: RTL

//  Multi-lane, mode-configurable masked conditional select for Boolean-masked
//  (2-share) operands. The select bit is never unmasked.
//  - Per lane, returns r0 or r1 without ever recombining the operand shares.
//  - Select comes from masked carries (sub/add reduction) or from an external masked bit.
//  - Fully pipelined: valid-tagged, accepts one transaction per cycle, zeroizable.
//  - Sits after the masked adder/subtractor stages in the masked modular reduction datapath.

---
 rtl/abr_masked_mux_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/abr_masked_mux_pipe.sv
// Masked conditional select r = s ? r0 : r1 on Boolean 2-share operands, 2-cycle pipeline.
// The select is never unmasked: it enters a DOM AND whose cross terms are refreshed.
module abr_masked_mux_pipe #(
  parameter int WIDTH     = 23,
  parameter int NUM_LANES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  zeroize,
  input  logic                                  valid_i,
  input  logic [1:0]                            mode_i,
  input  logic [NUM_LANES-1:0][1:0]             carry0_i,
  input  logic [NUM_LANES-1:0][1:0]             carry1_i,
  input  logic [NUM_LANES-1:0][1:0]             sel_i,
  input  logic [NUM_LANES-1:0][WIDTH-1:0][1:0]  r0_i,
  input  logic [NUM_LANES-1:0][WIDTH-1:0][1:0]  r1_i,
  input  logic [NUM_LANES*WIDTH-1:0]            rnd_xor_i,
  input  logic [NUM_LANES*WIDTH-1:0]            rnd_and_i,
  output logic                                  valid_o,
  output logic [NUM_LANES-1:0][WIDTH-1:0][1:0]  res_o,
  output logic                                  err_o
);

  typedef logic [NUM_LANES-1:0][WIDTH-1:0] plane_t;

  logic [NUM_LANES-1:0][1:0] c_sh;
  logic [NUM_LANES-1:0][1:0] s_sh;

  plane_t inner0_d, inner1_d, cross0_d, cross1_d, y0_d, y1_d;
  plane_t inner0_q, inner1_q, cross0_q, cross1_q, y0_q, y1_q;
  logic   v1, err1;

  logic [NUM_LANES-1:0][WIDTH-1:0][1:0] res_d;

  // Sharewise XOR keeps each share in its own domain; inverting one share negates the secret.
  always_comb begin
    c_sh = '0;
    s_sh = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      c_sh[l] = carry0_i[l] ^ carry1_i[l];
      case (mode_i)
        2'b01:   s_sh[l] = {c_sh[l][1], ~c_sh[l][0]};
        2'b10:   s_sh[l] = sel_i[l];
        default: s_sh[l] = carry0_i[l];
      endcase
    end
  end

  always_comb begin
    inner0_d = '0;
    inner1_d = '0;
    cross0_d = '0;
    cross1_d = '0;
    y0_d     = '0;
    y1_d     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int b = 0; b < WIDTH; b++) begin
        logic k, z, x0, x1;
        k  = rnd_xor_i[l*WIDTH + b];
        z  = rnd_and_i[l*WIDTH + b];
        x0 = r0_i[l][b][0] ^ r1_i[l][b][0] ^ k;
        x1 = r0_i[l][b][1] ^ r1_i[l][b][1] ^ k;
        inner0_d[l][b] = x0 & s_sh[l][0];
        inner1_d[l][b] = x1 & s_sh[l][1];
        cross0_d[l][b] = (x0 & s_sh[l][1]) ^ z;
        cross1_d[l][b] = (x1 & s_sh[l][0]) ^ z;
        y0_d[l][b]     = r1_i[l][b][0] ^ k;
        y1_d[l][b]     = r1_i[l][b][1] ^ k;
      end
    end
  end

  // DOM terms are compressed only after the register, so no glitch spans both shares.
  always_comb begin
    res_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int b = 0; b < WIDTH; b++) begin
        res_d[l][b][0] = inner0_q[l][b] ^ cross0_q[l][b] ^ y0_q[l][b];
        res_d[l][b][1] = inner1_q[l][b] ^ cross1_q[l][b] ^ y1_q[l][b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner0_q <= '0;
      inner1_q <= '0;
      cross0_q <= '0;
      cross1_q <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      v1       <= 1'b0;
      err1     <= 1'b0;
      valid_o  <= 1'b0;
      res_o    <= '0;
      err_o    <= 1'b0;
    end else if (zeroize) begin
      inner0_q <= '0;
      inner1_q <= '0;
      cross0_q <= '0;
      cross1_q <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      v1       <= 1'b0;
      err1     <= 1'b0;
      valid_o  <= 1'b0;
      res_o    <= '0;
      err_o    <= 1'b0;
    end else begin
      v1      <= valid_i;
      valid_o <= v1;
      if (valid_i) begin
        inner0_q <= inner0_d;
        inner1_q <= inner1_d;
        cross0_q <= cross0_d;
        cross1_q <= cross1_d;
        y0_q     <= y0_d;
        y1_q     <= y1_d;
        err1     <= (mode_i == 2'b11);
      end
      if (v1) begin
        res_o <= res_d;
        err_o <= err1;
      end
    end
  end

endmodule
